ysyx_exu_csr_seq: RTL

//  Multi-cycle sequencer for CSR-class instructions (CSRRW/S/C, immediate forms, ECALL, MRET) in the EXU.

---
 rtl/ysyx_exu_csr_seq_if.sv | 47 ++++
 rtl/ysyx_exu_csr_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_exu_csr_seq_if.sv
// rtl/ysyx_exu_csr_seq_if.sv - IDU/CSR-file/WBU signal bundle for the CSR sequencer
interface ysyx_exu_csr_seq_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [1:0]      in_sys;
   logic [2:0]      in_op;
   logic [11:0]     in_csr_addr;
   logic [XLEN-1:0] in_rs1_val;
   logic [4:0]      in_rs1_idx;
   logic [4:0]      in_rd;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_rdata;
   logic [XLEN-1:0] csr_mtvec;
   logic [XLEN-1:0] csr_mepc;
   logic            csr_wen;
   logic            csr_exu_valid;
   logic            csr_ecallen;
   logic [11:0]     csr_waddr_add1;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] csr_wdata_add1;
   logic            out_valid;
   logic            out_ready;
   logic [4:0]      out_rd;
   logic [XLEN-1:0] out_data;
   logic            out_redirect;
   logic [XLEN-1:0] out_npc;
   logic            out_illegal;

   modport slave (
      input  in_valid, in_pc, in_sys, in_op, in_csr_addr, in_rs1_val, in_rs1_idx, in_rd,
      input  csr_rdata, csr_mtvec, csr_mepc, out_ready,
      output in_ready, csr_addr, csr_wen, csr_exu_valid, csr_ecallen, csr_waddr_add1,
      output csr_wdata, csr_wdata_add1, out_valid, out_rd, out_data, out_redirect,
      output out_npc, out_illegal
   );

   modport master (
      output in_valid, in_pc, in_sys, in_op, in_csr_addr, in_rs1_val, in_rs1_idx, in_rd,
      output csr_rdata, csr_mtvec, csr_mepc, out_ready,
      input  in_ready, csr_addr, csr_wen, csr_exu_valid, csr_ecallen, csr_waddr_add1,
      input  csr_wdata, csr_wdata_add1, out_valid, out_rd, out_data, out_redirect,
      input  out_npc, out_illegal
   );
endinterface

// File: rtl/ysyx_exu_csr_seq.sv
// rtl/ysyx_exu_csr_seq.sv - IDLE/READ/WRITE/RESP sequencer for CSR, ECALL and MRET instructions
module ysyx_exu_csr_seq #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] MCAUSE_ECALL = XLEN'(11)
) (
   input logic                clk,
   input logic                rst,
   ysyx_exu_csr_seq_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t          state_q;
   logic [1:0]      sys_q;
   logic [2:0]      op_q;
   logic [XLEN-1:0] pc_q, rs1_val_q;
   logic [4:0]      rs1_idx_q, rd_q;
   logic [11:0]     csr_addr_q, waddr_add1_q;
   logic            in_ready_q, wen_q, exu_valid_q, ecallen_q;
   logic [XLEN-1:0] wdata_q, wdata_add1_q;
   logic            out_valid_q, redirect_q, illegal_q;
   logic [4:0]      out_rd_q;
   logic [XLEN-1:0] out_data_q, npc_q;

   logic            wen_d, ecallen_d, redirect_d, illegal_d, wr_op, csr_rw, csr_ro;
   logic [11:0]     waddr_add1_d;
   logic [XLEN-1:0] src, new_val, wdata_d, wdata_add1_d, out_data_d, npc_d;
   logic [4:0]      out_rd_d;

   // Decode of the latched instruction against the CSR values read in READ.
   always_comb begin
      src          = op_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_val_q;
      wr_op        = (op_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
      csr_rw       = (csr_addr_q == 12'h300) || (csr_addr_q == 12'h305) ||
                     (csr_addr_q == 12'h341) || (csr_addr_q == 12'h342);
      csr_ro       = (csr_addr_q == 12'hF11) || (csr_addr_q == 12'hF12);
      new_val      = src;
      wen_d        = 1'b0;
      ecallen_d    = 1'b0;
      redirect_d   = 1'b0;
      illegal_d    = 1'b0;
      waddr_add1_d = 12'h000;
      wdata_d      = '0;
      wdata_add1_d = '0;
      out_data_d   = '0;
      npc_d        = '0;
      out_rd_d     = 5'd0;
      case (op_q[1:0])
         2'b10:   new_val = bus.csr_rdata | src;
         2'b11:   new_val = bus.csr_rdata & ~src;
         default: new_val = src;
      endcase
      case (sys_q)
         2'b00: begin
            if (!(csr_rw || csr_ro) || op_q[1:0] == 2'b00 || (csr_ro && wr_op)) begin
               illegal_d = 1'b1;
            end else begin
               wen_d      = wr_op;
               wdata_d    = new_val;
               out_rd_d   = rd_q;
               out_data_d = bus.csr_rdata;
            end
         end
         2'b01: begin
            wen_d        = 1'b1;
            ecallen_d    = 1'b1;
            wdata_d      = pc_q;
            waddr_add1_d = 12'h342;
            wdata_add1_d = MCAUSE_ECALL;
            redirect_d   = 1'b1;
            npc_d        = bus.csr_mtvec;
         end
         2'b10: begin
            redirect_d = 1'b1;
            npc_d      = bus.csr_mepc;
         end
         default: illegal_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         sys_q        <= 2'b00;
         op_q         <= 3'b000;
         pc_q         <= '0;
         rs1_val_q    <= '0;
         rs1_idx_q    <= 5'd0;
         rd_q         <= 5'd0;
         csr_addr_q   <= 12'h000;
         in_ready_q   <= 1'b1;
         wen_q        <= 1'b0;
         exu_valid_q  <= 1'b0;
         ecallen_q    <= 1'b0;
         waddr_add1_q <= 12'h000;
         wdata_q      <= '0;
         wdata_add1_q <= '0;
         out_valid_q  <= 1'b0;
         out_rd_q     <= 5'd0;
         out_data_q   <= '0;
         redirect_q   <= 1'b0;
         npc_q        <= '0;
         illegal_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               sys_q      <= bus.in_sys;
               op_q       <= bus.in_op;
               pc_q       <= bus.in_pc;
               rs1_val_q  <= bus.in_rs1_val;
               rs1_idx_q  <= bus.in_rs1_idx;
               rd_q       <= bus.in_rd;
               csr_addr_q <= (bus.in_sys != 2'b00) ? 12'h341 : bus.in_csr_addr;
               in_ready_q <= 1'b0;
               state_q    <= READ;
            end
            READ: begin
               exu_valid_q  <= 1'b1;
               wen_q        <= wen_d;
               ecallen_q    <= ecallen_d;
               wdata_q      <= wdata_d;
               waddr_add1_q <= waddr_add1_d;
               wdata_add1_q <= wdata_add1_d;
               out_rd_q     <= out_rd_d;
               out_data_q   <= out_data_d;
               redirect_q   <= redirect_d;
               npc_q        <= npc_d;
               illegal_q    <= illegal_d;
               state_q      <= WRITE;
            end
            WRITE: begin
               exu_valid_q <= 1'b0;
               wen_q       <= 1'b0;
               ecallen_q   <= 1'b0;
               out_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: if (bus.out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready       = in_ready_q;
   assign bus.csr_addr       = csr_addr_q;
   assign bus.csr_wen        = wen_q;
   assign bus.csr_exu_valid  = exu_valid_q;
   assign bus.csr_ecallen    = ecallen_q;
   assign bus.csr_waddr_add1 = waddr_add1_q;
   assign bus.csr_wdata      = wdata_q;
   assign bus.csr_wdata_add1 = wdata_add1_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_rd         = out_rd_q;
   assign bus.out_data       = out_data_q;
   assign bus.out_redirect   = redirect_q;
   assign bus.out_npc        = npc_q;
   assign bus.out_illegal    = illegal_q;
endmodule
